// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding controller: pipeline optype
// encoding, operand-forward select codes and the forward-select priority chain.
package hazard_pkg;

  // Hazard class carried by each in-flight instruction.
  typedef enum logic [1:0] {
    OPT_NONE  = 2'b00,
    OPT_ALU   = 2'b01,
    OPT_LOAD  = 2'b10,
    OPT_STORE = 2'b11
  } optype_e;

  // Operand-forward mux selects seen by the EXE stage.
  localparam logic [2:0] FWD_RF      = 3'd0;
  localparam logic [2:0] FWD_EXE     = 3'd1;
  localparam logic [2:0] FWD_MEM_ALU = 3'd2;
  localparam logic [2:0] FWD_MEM_LD  = 3'd3;
  localparam logic [2:0] FWD_WB      = 3'd4;

  // Per-stage register match for one ID source operand.
  typedef struct packed {
    logic exe;
    logic mem;
    logic wb;
  } src_match_t;

  // Youngest producer wins: EXE, then MEM, then WB.
  function automatic logic [2:0] fwd_select(input src_match_t m,
                                            input optype_e    opt_exe,
                                            input optype_e    opt_mem,
                                            input optype_e    opt_wb);
    if (m.exe && opt_exe == OPT_ALU)                          return FWD_EXE;
    if (m.mem && opt_mem == OPT_ALU)                          return FWD_MEM_ALU;
    if (m.mem && opt_mem == OPT_LOAD)                         return FWD_MEM_LD;
    if (m.wb && (opt_wb == OPT_ALU || opt_wb == OPT_LOAD))    return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_mc_tracker.sv
// Multi-cycle EXE occupancy tracker. A MUL/DIV entering EXE loads the
// remaining-cycle count; the unit is busy while the count is nonzero.
module hazard_mc_tracker #(
  parameter int unsigned MC_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,     // multi-cycle op latched into EXE this edge
  output logic mc_busy_o
);

  localparam int unsigned CW = $clog2(MC_LAT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MC_LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: reload on a new op, otherwise count down to zero.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register, cleared asynchronously so a reset mid-op drops busy at once.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign mc_busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller for the 5-stage core, sitting beside ID.
// Tracks each in-flight instruction's optype through EXE/MEM/WB, resolves
// load-use and multi-cycle stalls, branch flushes and operand forwarding.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined;
// otherwise stall_cycles/flush_count are tied to zero.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Branch_ID,
  input  logic              rs1use_ID,
  input  logic              rs2use_ID,
  input  logic              mc_ID,
  input  logic [1:0]        hazard_optype_ID,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic [REG_AW-1:0] rd_EXE,
  input  logic [REG_AW-1:0] rd_MEM,
  input  logic [REG_AW-1:0] rd_WB,
  input  logic [REG_AW-1:0] rs2_EXE,
  output logic              PC_EN_IF,
  output logic              reg_FD_EN,
  output logic              reg_FD_flush,
  output logic              reg_DE_EN,
  output logic              reg_DE_flush,
  output logic              reg_EM_EN,
  output logic              reg_EM_flush,
  output logic              reg_MW_EN,
  output logic [2:0]        forward_ctrl_A,
  output logic [2:0]        forward_ctrl_B,
  output logic              forward_ctrl_ls,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  optype_e opt_id;
  optype_e opt_exe_q, opt_mem_q, opt_wb_q;
  optype_e opt_exe_d, opt_mem_d, opt_wb_d;
  src_match_t match_a, match_b;
  logic load_use;
  logic mc_start;

  assign opt_id = optype_e'(hazard_optype_ID);

  // A source depends on a producer only if it is really read and rd is not x0.
  function automatic logic src_hit(input logic use_f,
                                   input logic [REG_AW-1:0] rs,
                                   input logic [REG_AW-1:0] rd);
    return use_f && (rd != '0) && (rs == rd);
  endfunction

  assign match_a = '{exe: src_hit(rs1use_ID, rs1_ID, rd_EXE),
                     mem: src_hit(rs1use_ID, rs1_ID, rd_MEM),
                     wb:  src_hit(rs1use_ID, rs1_ID, rd_WB)};
  assign match_b = '{exe: src_hit(rs2use_ID, rs2_ID, rd_EXE),
                     mem: src_hit(rs2use_ID, rs2_ID, rd_MEM),
                     wb:  src_hit(rs2use_ID, rs2_ID, rd_WB)};

  // Load in EXE feeding ID. A store's rs2 is only data, which the MEM-load
  // path supplies one cycle later, so it does not stall.
  assign load_use = (opt_exe_q == OPT_LOAD) &&
                    (match_a.exe || (match_b.exe && opt_id != OPT_STORE));

  assign forward_ctrl_A  = fwd_select(match_a, opt_exe_q, opt_mem_q, opt_wb_q);
  assign forward_ctrl_B  = fwd_select(match_b, opt_exe_q, opt_mem_q, opt_wb_q);
  assign forward_ctrl_ls = (rd_MEM != '0) && (rs2_EXE == rd_MEM) &&
                           (opt_exe_q == OPT_STORE) && (opt_mem_q == OPT_LOAD);

  assign reg_EM_EN = 1'b1;
  assign reg_MW_EN = 1'b1;

  // Pipeline enables/flushes; busy beats load-use beats branch, so a branch
  // seen under a stall is simply re-evaluated once the stall clears.
  always_comb begin
    PC_EN_IF     = 1'b1;
    reg_FD_EN    = 1'b1;
    reg_FD_flush = 1'b0;
    reg_DE_EN    = 1'b1;
    reg_DE_flush = 1'b0;
    reg_EM_flush = 1'b0;
    if (mc_busy) begin
      PC_EN_IF     = 1'b0;
      reg_FD_EN    = 1'b0;
      reg_DE_EN    = 1'b0;
      reg_EM_flush = 1'b1;
    end else if (load_use) begin
      PC_EN_IF     = 1'b0;
      reg_FD_EN    = 1'b0;
      reg_DE_flush = 1'b1;
    end else begin
      reg_FD_flush = Branch_ID;
    end
  end

  // A multi-cycle op starts only when it really enters EXE.
  assign mc_start = mc_ID && !reg_DE_flush && !mc_busy;

  hazard_mc_tracker #(
    .MC_LAT(MC_LAT)
  ) u_mc_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (mc_start),
    .mc_busy_o(mc_busy)
  );

  // Optype shift: while busy EXE holds its op and MEM receives a bubble.
  always_comb begin
    opt_wb_d = opt_mem_q;
    if (mc_busy) begin
      opt_exe_d = opt_exe_q;
      opt_mem_d = OPT_NONE;
    end else begin
      opt_exe_d = reg_DE_flush ? OPT_NONE : opt_id;
      opt_mem_d = opt_exe_q;
    end
  end

  // Optype registers for EXE/MEM/WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opt_exe_q <= OPT_NONE;
      opt_mem_q <= OPT_NONE;
      opt_wb_q  <= OPT_NONE;
    end else begin
      opt_exe_q <= opt_exe_d;
      opt_mem_q <= opt_mem_d;
      opt_wb_q  <= opt_wb_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Saturating counts of front-end stall cycles and IF/ID flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!PC_EN_IF && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (reg_FD_flush && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: directed cycle table from reset,
// randomized cycles against a behavioural pipeline model, and hand-written
// perf-counter / reset-mid-busy sequences.
module tb_hazard_unit_mc;

  localparam int REG_AW = 5;
  localparam int MC_LAT = 4;
  localparam int CNT_W  = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic Branch_ID, rs1use_ID, rs2use_ID, mc_ID;
  logic [1:0] hazard_optype_ID;
  logic [REG_AW-1:0] rs1_ID, rs2_ID, rd_EXE, rd_MEM, rd_WB, rs2_EXE;
  logic PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush;
  logic reg_EM_EN, reg_EM_flush, reg_MW_EN;
  logic [2:0] forward_ctrl_A, forward_ctrl_B;
  logic forward_ctrl_ls, mc_busy;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(REG_AW), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .Branch_ID(Branch_ID),
    .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID), .mc_ID(mc_ID),
    .hazard_optype_ID(hazard_optype_ID),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_EXE(rd_EXE), .rd_MEM(rd_MEM),
    .rd_WB(rd_WB), .rs2_EXE(rs2_EXE),
    .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN), .reg_FD_flush(reg_FD_flush),
    .reg_DE_EN(reg_DE_EN), .reg_DE_flush(reg_DE_flush), .reg_EM_EN(reg_EM_EN),
    .reg_EM_flush(reg_EM_flush), .reg_MW_EN(reg_MW_EN),
    .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
    .forward_ctrl_ls(forward_ctrl_ls), .mc_busy(mc_busy),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic pc, input logic fden,
                            input logic fdfl, input logic deen, input logic defl,
                            input logic emfl, input logic busy,
                            input logic [2:0] fa, input logic [2:0] fb, input logic ls);
    check({tag, ".PC_EN_IF"},        64'(PC_EN_IF),        64'(pc));
    check({tag, ".reg_FD_EN"},       64'(reg_FD_EN),       64'(fden));
    check({tag, ".reg_FD_flush"},    64'(reg_FD_flush),    64'(fdfl));
    check({tag, ".reg_DE_EN"},       64'(reg_DE_EN),       64'(deen));
    check({tag, ".reg_DE_flush"},    64'(reg_DE_flush),    64'(defl));
    check({tag, ".reg_EM_EN"},       64'(reg_EM_EN),       64'(1'b1));
    check({tag, ".reg_EM_flush"},    64'(reg_EM_flush),    64'(emfl));
    check({tag, ".reg_MW_EN"},       64'(reg_MW_EN),       64'(1'b1));
    check({tag, ".mc_busy"},         64'(mc_busy),         64'(busy));
    check({tag, ".forward_ctrl_A"},  64'(forward_ctrl_A),  64'(fa));
    check({tag, ".forward_ctrl_B"},  64'(forward_ctrl_B),  64'(fb));
    check({tag, ".forward_ctrl_ls"}, 64'(forward_ctrl_ls), 64'(ls));
  endtask

  task automatic set_in(input int br, input int u1, input int u2, input int mc, input int opt,
                        input int rs1, input int rs2, input int rde, input int rdm,
                        input int rdw, input int rs2e);
    Branch_ID = (br != 0); rs1use_ID = (u1 != 0); rs2use_ID = (u2 != 0); mc_ID = (mc != 0);
    hazard_optype_ID = 2'(opt);
    rs1_ID = 5'(rs1); rs2_ID = 5'(rs2); rd_EXE = 5'(rde); rd_MEM = 5'(rdm);
    rd_WB = 5'(rdw); rs2_EXE = 5'(rs2e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs({tag, ".in_reset"}, 1, 1, 0, 1, 0, 0, 0, 3'd0, 3'd0, 0);
    check({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(0));
    check({tag, ".flush_count"},  64'(flush_count),  64'(0));
    rst_n = 1'b1;
    next_cycle();
  endtask

  // ---------------- directed table ----------------
  typedef enum int {C_RUN, C_LU, C_BUSY} ctl_e;
  typedef struct {
    int br, u1, u2, mc, opt, rs1, rs2, rde, rdm, rdw, rs2e;
    ctl_e ctl;
    int fdfl, fa, fb, ls;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input int br, input int u1, input int u2, input int mc,
                              input int opt, input int rs1, input int rs2, input int rde,
                              input int rdm, input int rdw, input int rs2e, input ctl_e ctl,
                              input int fdfl, input int fa, input int fb, input int ls);
    vec_t v;
    v.br = br; v.u1 = u1; v.u2 = u2; v.mc = mc; v.opt = opt;
    v.rs1 = rs1; v.rs2 = rs2; v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.rs2e = rs2e;
    v.ctl = ctl; v.fdfl = fdfl; v.fa = fa; v.fb = fb; v.ls = ls;
    return v;
  endfunction

  // {pc, fd_en, de_en, de_flush, em_flush, busy}
  function automatic logic [5:0] ctl_bits(input ctl_e c);
    case (c)
      C_LU:    return 6'b001100;
      C_BUSY:  return 6'b000011;
      default: return 6'b111000;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  int mp[3];          // optype held by the instruction in EXE, MEM, WB
  int m_busy_left;    // cycles of multi-cycle occupancy still to come
  longint m_stall, m_flush;

  function automatic bit hit(input logic u, input logic [4:0] rs, input logic [4:0] rd);
    return u && (rd != 0) && (rs == rd);
  endfunction

  function automatic int fwd(input logic u, input logic [4:0] rs);
    if (hit(u, rs, rd_EXE) && mp[0] == 1)                  return 1;
    if (hit(u, rs, rd_MEM) && mp[1] == 1)                  return 2;
    if (hit(u, rs, rd_MEM) && mp[1] == 2)                  return 3;
    if (hit(u, rs, rd_WB) && (mp[2] == 1 || mp[2] == 2))   return 4;
    return 0;
  endfunction

  task automatic model_reset();
    mp[0] = 0; mp[1] = 0; mp[2] = 0;
    m_busy_left = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_cycle(input int c);
    bit busy, lu, pc, fden, fdfl, deen, defl, emfl, ls;
    string tag;
    tag = $sformatf("rnd%0d", c);
    busy = (m_busy_left > 0);
    lu = (mp[0] == 2) && (hit(rs1use_ID, rs1_ID, rd_EXE) ||
                          (hit(rs2use_ID, rs2_ID, rd_EXE) && hazard_optype_ID != 2'b11));
    pc = 1; fden = 1; deen = 1; defl = 0; emfl = 0; fdfl = 0;
    if (busy) begin
      pc = 0; fden = 0; deen = 0; emfl = 1;
    end else if (lu) begin
      pc = 0; fden = 0; defl = 1;
    end else begin
      fdfl = Branch_ID;
    end
    ls = (rd_MEM != 0) && (rs2_EXE == rd_MEM) && mp[0] == 3 && mp[1] == 2;
    check_outs(tag, pc, fden, fdfl, deen, defl, emfl, busy,
               3'(fwd(rs1use_ID, rs1_ID)), 3'(fwd(rs2use_ID, rs2_ID)), ls);
    check({tag, ".stall_cycles"}, 64'(stall_cycles), PERF ? 64'(m_stall) : 64'(0));
    check({tag, ".flush_count"},  64'(flush_count),  PERF ? 64'(m_flush) : 64'(0));
    // advance model across the coming edge
    if (!pc && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (fdfl && m_flush < 64'hFFFF_FFFF) m_flush++;
    mp[2] = mp[1];
    if (busy) begin
      mp[1] = 0;
      m_busy_left--;
    end else begin
      mp[1] = mp[0];
      mp[0] = defl ? 0 : int'(hazard_optype_ID);
      if (mc_ID && !defl) m_busy_left = MC_LAT - 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] cb;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset("rst0");

    //          br u1 u2 mc op rs1 rs2 rde rdm rdw rs2e ctl   fdfl fa fb ls
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0, C_RUN,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1,  0, 0,  0,  0, 0, 0, C_RUN,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1,  5, 0,  5,  0, 0, 0, C_RUN,  0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0,  0, 7,  0,  7, 0, 0, C_RUN,  0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2,  9, 0,  0,  0, 9, 0, C_RUN,  0, 4, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1,  0, 6,  6,  0, 0, 0, C_LU,   0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1,  0, 6,  0,  6, 0, 0, C_RUN,  1, 0, 3, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2,  4, 0,  3,  0, 4, 0, C_RUN,  0, 4, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 3,  2, 6,  6,  0, 0, 0, C_RUN,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2,  0, 0,  0,  6, 0, 6, C_RUN,  0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 3,  6, 8,  6,  0, 0, 0, C_LU,   0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 3,  6, 8,  0,  6, 0, 0, C_RUN,  0, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1,  0, 0,  0,  5, 0, 5, C_RUN,  0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 10, 0, 10,  0, 0, 0, C_BUSY, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 10, 0, 10,  0, 0, 0, C_BUSY, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 10, 0, 10,  0, 0, 0, C_BUSY, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 10, 0, 10,  0, 0, 0, C_RUN,  1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2,  0, 0,  0,  0, 0, 0, C_RUN,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 12, 0, 12,  0, 0, 0, C_LU,   0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 12, 0,  0, 12, 0, 0, C_RUN,  0, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0, C_BUSY, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].br, tbl[i].u1, tbl[i].u2, tbl[i].mc, tbl[i].opt, tbl[i].rs1,
             tbl[i].rs2, tbl[i].rde, tbl[i].rdm, tbl[i].rdw, tbl[i].rs2e);
      @(negedge clk);
      cb = ctl_bits(tbl[i].ctl);
      check_outs($sformatf("v%0d", i), cb[5], cb[4], tbl[i].fdfl != 0, cb[3], cb[2],
                 cb[1], cb[0], 3'(tbl[i].fa), 3'(tbl[i].fb), tbl[i].ls != 0);
      next_cycle();
    end

    // ---------------- randomized against the model ----------------
    do_reset("rst1");
    model_reset();
    for (int c = 0; c < 400; c++) begin
      set_in(($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 1)),
             int'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 1 : 0,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)));
      @(negedge clk);
      model_cycle(c);
      next_cycle();
    end

    // ---------------- perf counters: 3 busy + 1 load-use + 1 branch ----------------
    do_reset("rst2");
    set_in(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);           // DIV enters EXE
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("perf.busy%0d", k), 64'(mc_busy), 64'(1));
      next_cycle();
    end
    @(negedge clk);
    check("perf.busy_done", 64'(mc_busy), 64'(0));
    set_in(0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);           // load x6 enters EXE
    next_cycle();
    set_in(0, 1, 0, 0, 1, 6, 0, 6, 0, 0, 0);           // dependent add: load-use
    @(negedge clk);
    check("perf.lu_pc", 64'(PC_EN_IF), 64'(0));
    next_cycle();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);           // branch taken
    @(negedge clk);
    check("perf.br_flush", 64'(reg_FD_flush), 64'(1));
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("perf.stall_cycles", 64'(stall_cycles), PERF ? 64'(4) : 64'(0));
    check("perf.flush_count",  64'(flush_count),  PERF ? 64'(1) : 64'(0));
    next_cycle();

    // ---------------- reset asserted mid-busy ----------------
    set_in(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("midrst.busy_before", 64'(mc_busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midrst.busy",  64'(mc_busy), 64'(0));
    check("midrst.pc_en", 64'(PC_EN_IF), 64'(1));
    check("midrst.stall_cycles", 64'(stall_cycles), 64'(0));
    check("midrst.flush_count",  64'(flush_count),  64'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("midrst.after0", 64'(mc_busy), 64'(0));
    next_cycle();
    @(negedge clk);
    check("midrst.after1", 64'(mc_busy), 64'(0));
    check("midrst.after1_em_flush", 64'(reg_EM_flush), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
